// File: rtl/seq_multiplier_32bit.sv
// ---------------------------------------------------------------------------
// seq_multiplier_32bit
//
// Purpose:
//   Multi-cycle unsigned shift-add multiplier for the 32-bit ALU datapath.
//   One multiplier bit is retired per clock. The product register doubles as
//   the multiplier shift register: the low half starts out holding operand B
//   and is consumed from bit 0 upward, while partial sums build up in the
//   high half and shift down into the vacated low bits.
//
// Ports:
//   clk           in   1         system clock, all state updates on rising edge
//   reset         in   1         synchronous, active-high reset
//   start         in   1         begin a multiply (only honoured in IDLE)
//   multiplicand  in   WIDTH     operand A, latched when start is accepted
//   multiplier    in   WIDTH     operand B, latched when start is accepted
//   product       out  2*WIDTH   unsigned A*B, valid while done=1 and held
//                                until the next accepted start
//   busy          out  1         high while the shift-add loop is running
//   done          out  1         one-cycle pulse, product is valid
//
// Timing:
//   start accepted at edge k -> RUN for WIDTH edges -> DONE for one cycle ->
//   done pulses in the cycle after edge k+WIDTH+1 (33 edges for WIDTH=32).
//   With start held high the next operation is accepted on the edge right
//   after the done pulse appears, giving one result every WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module seq_multiplier_32bit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    // One extra counter bit so the count can never wrap inside an operation.
    localparam int COUNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         addend;

    // Next-state and datapath logic. In RUN the high half of the product
    // conditionally absorbs the multiplicand (when the current multiplier
    // bit, product[0], is set) at WIDTH+1 bits so the carry survives, then
    // the whole register shifts right by one with that carry as its new MSB.
    // The done pulse is raised on the edge that leaves DONE, which places it
    // one cycle after the DONE state itself and keeps done/busy registered.
    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        done_d    = 1'b0;
        addend    = product_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}};
        sum       = {1'b0, product_q[2*WIDTH-1:WIDTH]} + addend;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d   = multiplicand;
                    product_d = {{WIDTH{1'b0}}, multiplier};
                    count_d   = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                product_d = {sum, product_q[WIDTH-1:1]};
                count_d   = count_q + COUNT_W'(1);
                if (count_q == COUNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    // All state and the registered busy/done outputs. Reset is synchronous
    // and takes priority over everything, so a reset during RUN simply
    // abandons the operation without ever producing a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            product_q <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier_32bit
//
// Self-checking bench for seq_multiplier_32bit. Expected products are pushed
// onto a scoreboard queue when a multiply is launched and popped when done
// pulses. A table of vectors covers the main function; hand-written
// sequences cover the ignored mid-run start, reset mid-run and back-to-back
// operation with start held high.
// ---------------------------------------------------------------------------
module tb_seq_multiplier_32bit;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 1;
    localparam int PERIOD  = WIDTH + 2;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] expected;
    } vector_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    int                   n_checks = 0;
    int                   n_fail   = 0;
    logic [2*WIDTH-1:0]   exp_q[$];
    vector_t              vectors[12];

    seq_multiplier_32bit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Safety net in case the DUT or bench wedges.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [2*WIDTH-1:0] actual,
                               input logic [2*WIDTH-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive a start request before the next rising edge and record the
    // product the bench expects for it.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2*WIDTH-1:0] expected);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        exp_q.push_back(expected);
    endtask

    // Let the accepting edge pass, then watch the operation to completion.
    // glitch_at > 0 pulses start with new operands at that RUN cycle;
    // reset_at > 0 asserts reset for one edge at that RUN cycle.
    task automatic waitForDone(input string name, input int glitch_at, input int reset_at);
        int busy_cycles;
        int done_pulses;
        int latency;
        bit aborted;
        logic [2*WIDTH-1:0] exp_val;

        busy_cycles = 0;
        done_pulses = 0;
        latency     = -1;
        aborted     = 1'b0;

        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        checkOutput({name, " busy after accept"}, 64'(busy), 64'd1);
        if (busy) busy_cycles++;

        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == glitch_at) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end
            if (cyc == reset_at) reset = 1'b1;
            @(posedge clk);
            #1;
            if (cyc == glitch_at) begin
                start        = 1'b0;
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            if (cyc == reset_at) begin
                reset   = 1'b0;
                aborted = 1'b1;
                checkOutput({name, " product after reset"}, product, 64'd0);
                checkOutput({name, " busy after reset"}, 64'(busy), 64'd0);
                checkOutput({name, " done after reset"}, 64'(done), 64'd0);
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (done_pulses == 1) begin
                    latency = cyc;
                    checkOutput({name, " busy low with done"}, 64'(busy), 64'd0);
                    if (exp_q.size() == 0) begin
                        checkOutput({name, " unexpected done (empty scoreboard)"}, 64'd1, 64'd0);
                    end else begin
                        exp_val = exp_q.pop_front();
                        checkOutput({name, " product"}, product, exp_val);
                    end
                end
            end
        end

        if (aborted) begin
            checkOutput({name, " no done after abort"}, 64'(done_pulses), 64'd0);
            if (exp_q.size() > 0) exp_val = exp_q.pop_front();
        end else begin
            checkOutput({name, " done pulse count"}, 64'(done_pulses), 64'd1);
            checkOutput({name, " latency"}, 64'(latency), 64'(LATENCY));
            checkOutput({name, " busy cycles"}, 64'(busy_cycles), 64'(WIDTH));
        end
    endtask

    // Hold start high and check three consecutive results and their spacing.
    task automatic runBackToBack();
        int done_seen;
        int done_cycle[3];
        logic [2*WIDTH-1:0] exp_val;

        done_seen = 0;
        @(negedge clk);
        multiplicand = 32'd10;
        multiplier   = 32'd10;
        start        = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(64'd100);

        for (int cyc = 1; cyc <= 150 && done_seen < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cycle[done_seen] = cyc;
                done_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("b2b unexpected done (empty scoreboard)", 64'd1, 64'd0);
                end else begin
                    exp_val = exp_q.pop_front();
                    checkOutput("b2b product", product, exp_val);
                end
            end
        end
        start = 1'b0;

        checkOutput("b2b done count", 64'(done_seen), 64'd3);
        if (done_seen == 3) begin
            checkOutput("b2b first latency", 64'(done_cycle[0]), 64'(LATENCY + 1));
            checkOutput("b2b spacing 1", 64'(done_cycle[1] - done_cycle[0]), 64'(PERIOD));
            checkOutput("b2b spacing 2", 64'(done_cycle[2] - done_cycle[1]), 64'(PERIOD));
        end
        while (exp_q.size() > 0) exp_val = exp_q.pop_front();

        repeat (40) @(posedge clk);
        #1;
        checkOutput("b2b idle afterwards", 64'(busy), 64'd0);
    endtask

    initial begin
        vectors[0]  = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vectors[1]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vectors[2]  = '{32'h0,          32'hDEAD_BEEF,  64'h0};
        vectors[3]  = '{32'h1234_5678,  32'd1,          64'h0000_0000_1234_5678};
        vectors[4]  = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
        vectors[5]  = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vectors[6]  = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vectors[7]  = '{32'hDEAD_BEEF,  32'h0,          64'h0};
        for (int i = 8; i < 12; i++) begin
            vectors[i].a        = $urandom;
            vectors[i].b        = $urandom;
            vectors[i].expected = 64'(vectors[i].a) * 64'(vectors[i].b);
        end

        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset product", product, 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);

        // Reset must win over a simultaneous start.
        start        = 1'b1;
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        @(posedge clk);
        #1;
        checkOutput("reset dominates start busy", 64'(busy), 64'd0);
        checkOutput("reset dominates start product", product, 64'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].expected);
            waitForDone($sformatf("vec%0d", i), 0, 0);
        end

        $display("[TB] ignored start during RUN");
        applyStimulus(32'd7, 32'd6, 64'd42);
        waitForDone("ignored start", 10, 0);

        $display("[TB] reset during RUN");
        applyStimulus(32'd100, 32'd200, 64'd20000);
        waitForDone("reset mid-run", 0, 15);
        applyStimulus(32'd2, 32'd21, 64'd42);
        waitForDone("after reset", 0, 0);

        $display("[TB] back-to-back with start held");
        runBackToBack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
